vrf_read_arbiter: RTL and testbench
===================================

VRF_READ_ARBITER -- requirements
Module: vrf_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read pipes sharing one VRF read port (2..8).
REQ-002 SHALL have parameter READ_LATENCY, default 2, cycles from VRF request fire to vrfReadResult valid (1..4).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester read request valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester grant and accept.
REQ-007 SHALL have port req_vs  input  NUM_REQ*5  packed vector register index per requester.
REQ-008 SHALL have port req_offset  input  NUM_REQ*6  packed offset per requester.
REQ-009 SHALL have port req_instructionIndex  input  NUM_REQ*3  packed instruction tag per requester.
REQ-010 SHALL have port flush  input  1  discard all in-flight responses.
REQ-011 SHALL have port vrfReadRequest_ready  input  1  VRF port accepts request.
REQ-012 SHALL have port vrfReadRequest_valid  output  1  request to VRF.
REQ-013 SHALL have ports vrfReadRequest_bits_vs/offset/instructionIndex  output  5/6/3  fields of the granted requester.
REQ-014 SHALL have port vrfReadRequest_bits_readSource  output  2  binary id of the granted requester, low 2 bits.
REQ-015 SHALL have port vrfReadResult  input  32  VRF read data, valid READ_LATENCY cycles after fire.
REQ-016 SHALL have port resp_valid  output  NUM_REQ  one-hot response strobe.
REQ-017 SHALL have port resp_data  output  32  response data, broadcast to all requesters.
REQ-018 SHALL have port inflight  output  3  count of issued, not yet returned reads.

Function
REQ-019 SHALL grant by round-robin: highest priority goes to the index after the last granted; the search wraps from NUM_REQ-1 to 0.
REQ-020 SHALL assert vrfReadRequest_valid combinationally when any req_valid is high, and drive the fields of the granted requester.
REQ-021 SHALL assert req_ready[i] only when i is granted and vrfReadRequest_ready=1; at most one req_ready bit is high.
REQ-022 SHALL advance the round-robin pointer only on fire (valid & ready); a stalled grant holds the pointer.
REQ-023 SHALL shift a fire flag and requester id through a READ_LATENCY-deep pipeline every cycle.
REQ-024 SHALL drive resp_valid[id]=1 and resp_data=vrfReadResult in the cycle the pipeline tail flag is set.
REQ-025 SHALL have no backpressure on responses; requesters sink them unconditionally.
REQ-026 SHALL, on flush=1, clear all pipeline flags at the next edge and suppress resp_valid in the flush cycle; requests still fire that cycle but are dropped.
REQ-027 SHALL set inflight = number of set pipeline flags; it never exceeds READ_LATENCY.
REQ-028 SHALL serve a single continuously valid requester every cycle, with no bubble.
REQ-029 SHALL hold all outputs at 0 when no req_valid is high, except pipeline-driven resp and inflight.

Reset
REQ-030 SHALL, on reset, clear the round-robin pointer to NUM_REQ-1 so that index 0 wins first.
REQ-031 SHALL, on reset, clear pipeline flags; resp_valid=0 and inflight=0 in the cycle after reset.
REQ-032 SHALL drop in-flight reads when reset is asserted mid-operation; no response is produced for them.
REQ-033 SHALL leave the pipeline id and data registers without reset.

Structure
REQ-034 SHALL place the field widths (vs 5, offset 6, instructionIndex 3, data 32) and the read-request struct typedef in the shared VRF package.
REQ-035 SHALL implement the round-robin pick as sub-module rr_grant (request vector, pointer -> one-hot grant), reusable elsewhere.

Verification
REQ-036 SHALL verify reset: reset for 2 cycles, then req_valid=4'b1111 and ready=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-037 SHALL verify stall: req_valid=4'b0110, ready=0 for 3 cycles, then 1 -> req1 granted and held stable, then req2 the next cycle.
REQ-038 SHALL verify latency: req3 fires at cycle t and vrfReadResult=32'hDEADBEEF at t+2 -> resp_valid=4'b1000 and resp_data=DEADBEEF at t+2; inflight=1 at t+1.
REQ-039 SHALL verify back-to-back: req0 is valid continuously for 5 cycles -> 5 fires and 5 responses to req0 in order; inflight is 2 in steady state.
REQ-040 SHALL verify flush: two reads are in flight and flush pulses 1 cycle -> no resp_valid for them and inflight=0 the next cycle.
REQ-041 SHALL verify reset mid-operation: reset asserted with 2 reads in flight -> no resp_valid after reset and the pointer restarts at 0.

Source files
------------

// File: rtl/vrf_read_arbiter_pkg.sv
// Shared VRF read-port definitions: field widths and the read-request bundle.
package vrf_read_arbiter_pkg;

    localparam int VS_W       = 5;
    localparam int OFFSET_W   = 6;
    localparam int INSTR_W    = 3;
    localparam int DATA_W     = 32;
    localparam int SOURCE_W   = 2;
    localparam int INFLIGHT_W = 3;

    typedef struct packed {
        logic [VS_W-1:0]     vs;
        logic [OFFSET_W-1:0] offset;
        logic [INSTR_W-1:0]  instructionIndex;
        logic [SOURCE_W-1:0] readSource;
    } vrf_read_req_t;

endpackage

// File: rtl/vrf_read_arbiter_rr_grant.sv
// Round-robin picker: one-hot grant to the first requester after ptr, wrapping.
module rr_grant #(
    parameter  int N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int               sum;

    // Scan ptr+1 .. ptr+N modulo N and grant the first active request.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 1; k <= N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrf_read_arbiter.sv
// Shares one VRF read port among NUM_REQ read pipes and routes the fixed-latency
// read results back to the requester that issued each read.
module vrf_read_arbiter
    import vrf_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*VS_W-1:0]     req_vs,
    input  logic [NUM_REQ*OFFSET_W-1:0] req_offset,
    input  logic [NUM_REQ*INSTR_W-1:0]  req_instructionIndex,
    input  logic                        flush,
    input  logic                        vrfReadRequest_ready,
    output logic                        vrfReadRequest_valid,
    output logic [VS_W-1:0]             vrfReadRequest_bits_vs,
    output logic [OFFSET_W-1:0]         vrfReadRequest_bits_offset,
    output logic [INSTR_W-1:0]          vrfReadRequest_bits_instructionIndex,
    output logic [SOURCE_W-1:0]         vrfReadRequest_bits_readSource,
    input  logic [DATA_W-1:0]           vrfReadResult,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic [INFLIGHT_W-1:0]       inflight
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]         rr_ptr;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_id;
    vrf_read_req_t           granted;
    logic                    fire;
    logic                    tail_valid;
    logic [READ_LATENCY-1:0] pipe_flag;
    logic [ID_W-1:0]         pipe_id [READ_LATENCY];

    rr_grant #(.N(NUM_REQ)) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot grant and select that requester's fields (all zero when idle).
    always_comb begin
        grant_id = '0;
        granted  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id                 = ID_W'(i);
                granted.vs               = req_vs[i*VS_W +: VS_W];
                granted.offset           = req_offset[i*OFFSET_W +: OFFSET_W];
                granted.instructionIndex = req_instructionIndex[i*INSTR_W +: INSTR_W];
            end
        end
        granted.readSource = SOURCE_W'(grant_id);
    end

    assign fire                                 = (|req_valid) & vrfReadRequest_ready;
    assign req_ready                            = grant & {NUM_REQ{vrfReadRequest_ready}};
    assign vrfReadRequest_valid                 = |req_valid;
    assign vrfReadRequest_bits_vs               = granted.vs;
    assign vrfReadRequest_bits_offset           = granted.offset;
    assign vrfReadRequest_bits_instructionIndex = granted.instructionIndex;
    assign vrfReadRequest_bits_readSource       = granted.readSource;

    // The pointer remembers the last winner and only moves when a request actually fires.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (fire) begin
            rr_ptr <= grant_id;
        end
    end

    // Fire flags track outstanding reads; flush or reset wipes them so those reads never answer.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            pipe_flag <= '0;
        end else begin
            pipe_flag[0] <= fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_flag[i] <= pipe_flag[i-1];
            end
        end
    end

    // Requester ids ride alongside the flags; their contents only matter where a flag is set.
    always_ff @(posedge clock) begin
        pipe_id[0] <= grant_id;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_id[i] <= pipe_id[i-1];
        end
    end

    assign tail_valid = pipe_flag[READ_LATENCY-1] & ~flush & ~reset;

    // Steer the returning read data to the requester recorded at the pipeline tail.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (tail_valid) begin
            resp_valid[pipe_id[READ_LATENCY-1]] = 1'b1;
            resp_data                           = vrfReadResult;
        end
    end

    // Count the reads that have been issued but not yet returned.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (pipe_flag[i]) begin
                inflight = inflight + INFLIGHT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vrf_read_arbiter.sv
// Randomised and directed bench for vrf_read_arbiter with a queue-based scoreboard.
module tb_vrf_read_arbiter;
    import vrf_read_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic                  clock;
    logic                  reset;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N*VS_W-1:0]     req_vs;
    logic [N*OFFSET_W-1:0] req_offset;
    logic [N*INSTR_W-1:0]  req_instructionIndex;
    logic                  flush;
    logic                  vrfReadRequest_ready;
    logic                  vrfReadRequest_valid;
    logic [VS_W-1:0]       vrfReadRequest_bits_vs;
    logic [OFFSET_W-1:0]   vrfReadRequest_bits_offset;
    logic [INSTR_W-1:0]    vrfReadRequest_bits_instructionIndex;
    logic [SOURCE_W-1:0]   vrfReadRequest_bits_readSource;
    logic [DATA_W-1:0]     vrfReadResult;
    logic [N-1:0]          resp_valid;
    logic [DATA_W-1:0]     resp_data;
    logic [INFLIGHT_W-1:0] inflight;

    vrf_read_arbiter #(.NUM_REQ(N), .READ_LATENCY(LAT)) dut (
        .clock                               (clock),
        .reset                               (reset),
        .req_valid                           (req_valid),
        .req_ready                           (req_ready),
        .req_vs                              (req_vs),
        .req_offset                          (req_offset),
        .req_instructionIndex                (req_instructionIndex),
        .flush                               (flush),
        .vrfReadRequest_ready                (vrfReadRequest_ready),
        .vrfReadRequest_valid                (vrfReadRequest_valid),
        .vrfReadRequest_bits_vs              (vrfReadRequest_bits_vs),
        .vrfReadRequest_bits_offset          (vrfReadRequest_bits_offset),
        .vrfReadRequest_bits_instructionIndex(vrfReadRequest_bits_instructionIndex),
        .vrfReadRequest_bits_readSource      (vrfReadRequest_bits_readSource),
        .vrfReadResult                       (vrfReadResult),
        .resp_valid                          (resp_valid),
        .resp_data                           (resp_data),
        .inflight                            (inflight)
    );

    typedef struct {
        int          id;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   dead_cyc  = -1;
    int   model_last = N - 1;

    int                  m_grant;
    logic [N-1:0]        m_ready;
    logic [VS_W-1:0]     m_vs;
    logic [OFFSET_W-1:0] m_offset;
    logic [INSTR_W-1:0]  m_instr;
    logic [SOURCE_W-1:0] m_source;
    exp_t                mon_e;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read data the bench presents on the VRF result bus in a given cycle.
    function automatic logic [31:0] data_at(int c);
        if (c == dead_cyc) return 32'hDEADBEEF;
        return (32'(c) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Round-robin reference: first valid index after the last winner, wrapping.
    function automatic int model_grant(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic fl, input logic rst);
        @(posedge clock);
        #1;
        cyc++;
        req_valid            = v;
        vrfReadRequest_ready = rdy;
        flush                = fl;
        reset                = rst;
        req_vs               = 20'($urandom);
        req_offset           = 24'($urandom);
        req_instructionIndex = 12'($urandom);
        vrfReadResult        = data_at(cyc);
    endtask

    // Reference model: checks the request side and pushes expected responses.
    always @(negedge clock) begin
        if (reset) begin
            sbq.delete();
            model_last = N - 1;
        end else begin
            m_grant  = model_grant(req_valid, model_last);
            m_ready  = '0;
            m_vs     = '0;
            m_offset = '0;
            m_instr  = '0;
            m_source = '0;
            if (m_grant >= 0) begin
                if (vrfReadRequest_ready) m_ready[m_grant] = 1'b1;
                m_vs     = VS_W'(req_vs >> (m_grant * VS_W));
                m_offset = OFFSET_W'(req_offset >> (m_grant * OFFSET_W));
                m_instr  = INSTR_W'(req_instructionIndex >> (m_grant * INSTR_W));
                m_source = SOURCE_W'(m_grant);
            end
            checkOutput("req_ready", req_ready, m_ready);
            checkOutput("vrf_valid", vrfReadRequest_valid, |req_valid);
            checkOutput("bits_vs", vrfReadRequest_bits_vs, m_vs);
            checkOutput("bits_offset", vrfReadRequest_bits_offset, m_offset);
            checkOutput("bits_instr", vrfReadRequest_bits_instructionIndex, m_instr);
            checkOutput("bits_source", vrfReadRequest_bits_readSource, m_source);
            checkOutput("inflight", inflight, sbq.size());
            if (flush) begin
                sbq.delete();
            end else if (m_grant >= 0 && vrfReadRequest_ready) begin
                sbq.push_back('{id: m_grant, due: cyc + LAT, data: data_at(cyc + LAT)});
            end
            if (m_grant >= 0 && vrfReadRequest_ready) model_last = m_grant;
        end
    end

    // Monitor: pops an expected response whenever the DUT presents one, or flags a missing one.
    always @(negedge clock) begin
        #1;
        if (resp_valid !== '0) begin
            if (sbq.size() == 0) begin
                checkOutput("resp_unexpected", resp_valid, 0);
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("resp_due", cyc, mon_e.due);
                checkOutput("resp_valid", resp_valid, N'(1) << mon_e.id);
                checkOutput("resp_data", resp_data, mon_e.data);
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e = sbq.pop_front();
            checkOutput("resp_missing", resp_valid, N'(1) << mon_e.id);
        end
    end

    initial begin
        reset                = 1'b1;
        req_valid            = '0;
        vrfReadRequest_ready = 1'b0;
        flush                = 1'b0;
        req_vs               = '0;
        req_offset           = '0;
        req_instructionIndex = '0;
        vrfReadResult        = data_at(0);

        // Reset for two cycles, then all four requesters contend.
        for (int i = 0; i < 2; i++) applyStimulus('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // Stalled grant must hold, then release in order.
        for (int i = 0; i < 3; i++) applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // Single read from requester 3 returning a known word.
        dead_cyc = cyc + 1 + LAT;
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // Back-to-back reads from requester 0.
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // Flush with two reads outstanding.
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // Reset with two reads outstanding, then the pointer must restart at 0.
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(N'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 79) == 0);
        end

        for (int i = 0; i < 6; i++) applyStimulus('0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        checkOutput("sbq_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
